// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the FSM state encoding and the byte/word geometry.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    // Word counter sticks at its maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input, instr_mem write port and status outputs of the loader.
// The loader uses the slave modport; the image source / memory side uses master.
interface instr_mem_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_last;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;
    logic [15:0]           word_count;

    modport master (
        output start, byte_valid, byte_data, byte_last,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
    );

    modport slave (
        input  start, byte_valid, byte_data, byte_last,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
    );
endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs incoming bytes into a little-endian word: byte k lands in bits [8k+7:8k].
// o_next_word is the word as it looks with the current byte inserted.
module word_assembler
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [7:0]            i_byte,
    output logic [BYTE_IDX_W-1:0] o_byte_idx,
    output logic                  o_word_full,
    output logic [WORD_W-1:0]     o_next_word
);

    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [WORD_W-1:0]     r_word;
    logic [WORD_W-1:0]     w_next_word;

    // A new word starts from zero, so a short final word comes out zero-padded.
    // NOTE: every variable in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next_word = (r_byte_idx == '0) ? '0 : r_word;
        w_next_word[{r_byte_idx, 3'b000} +: 8] = i_byte;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_idx <= '0;
            r_word     <= '0;
        end else if (i_push) begin
            r_word     <= w_next_word;
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

    assign o_byte_idx  = r_byte_idx;
    assign o_word_full = i_push && (r_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign o_next_word = w_next_word;

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program image in as bytes and writes it word by word into instr_mem,
// holding the CPU until the whole image has been written cleanly.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 256
) (
    input logic               clk,
    input logic               rst,
    instr_mem_loader_if.slave bus
);

    loader_state_t         r_state;
    loader_state_t         w_next_state;

    logic                  w_xfer;
    logic                  w_start_load;
    logic                  w_word_end;
    logic                  w_overflow;
    logic                  w_do_write;

    logic [BYTE_IDX_W-1:0] w_byte_idx;
    logic                  w_word_full;
    logic [WORD_W-1:0]     w_next_word;

    logic [31:0]           r_word_idx;
    logic [15:0]           r_word_count;
    logic                  r_partial;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_load),
        .i_push      (w_xfer),
        .i_byte      (bus.byte_data),
        .o_byte_idx  (w_byte_idx),
        .o_word_full (w_word_full),
        .o_next_word (w_next_word)
    );

    // A word ends on its 4th byte or on any byte flagged last; ending one at capacity overflows.
    always_comb begin
        w_xfer       = bus.byte_valid && (r_state == LOAD);
        w_start_load = bus.start && (r_state inside {IDLE, DONE, ERROR});
        w_word_end   = w_word_full || (w_xfer && bus.byte_last);
        w_overflow   = w_word_end && (r_word_idx == 32'(MAX_WORDS));
        w_do_write   = w_word_end && !w_overflow;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (w_start_load) w_next_state = LOAD;
            end
            LOAD: begin
                if (w_overflow)                      w_next_state = ERROR;
                else if (w_do_write && bus.byte_last) w_next_state = FLUSH;
            end
            FLUSH:   w_next_state = r_partial ? ERROR : DONE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_idx   <= '0;
            r_word_count <= '0;
            r_partial    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= BASE_ADDR;
            r_wr_data    <= '0;
        end else begin
            r_wr_en <= w_do_write;
            if (w_start_load) begin
                r_word_idx   <= '0;
                r_word_count <= '0;
            end else if (w_do_write) begin
                r_wr_addr    <= BASE_ADDR + ADDR_WIDTH'(r_word_idx * 32'(BYTES_PER_WORD));
                r_wr_data    <= DATA_WIDTH'(w_next_word);
                r_word_idx   <= r_word_idx + 32'd1;
                r_word_count <= sat_inc16(r_word_count);
            end
            if (w_xfer && bus.byte_last) begin
                r_partial <= (w_byte_idx != BYTE_IDX_W'(BYTES_PER_WORD - 1));
            end
        end
    end

    assign bus.byte_ready = (r_state == LOAD);
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.cpu_hold   = (r_state != DONE);
    assign bus.done       = (r_state == DONE);
    assign bus.error      = (r_state == ERROR);
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: reset, clean loads, gapped stream,
// partial final word, overflow on a 4-word instance, and reset mid-load.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_wr     = 0;
    int   n_wr_s   = 0;
    int   base;

    logic [7:0] img [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    instr_mem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_s ();

    instr_mem_loader #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h0),
        .MAX_WORDS  (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_mem_loader #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h0),
        .MAX_WORDS  (4)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1)   n_wr++;
        if (bus_s.wr_en === 1'b1) n_wr_s++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        bus.byte_last  = last;
        step();
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.byte_valid   = 1'b0;
        bus.byte_data    = 8'h00;
        bus.byte_last    = 1'b0;
        bus_s.start      = 1'b0;
        bus_s.byte_valid = 1'b0;
        bus_s.byte_data  = 8'h00;
        bus_s.byte_last  = 1'b0;

        // Reset held for two cycles
        step();
        step();
        check("rst_cpu_hold",   bus.cpu_hold,   1);
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_wr_en",      bus.wr_en,      0);
        check("rst_done",       bus.done,       0);
        check("rst_error",      bus.error,      0);
        check("rst_word_count", bus.word_count, 0);
        check("rst_wr_addr",    bus.wr_addr,    32'h0);
        check("rst_wr_data",    bus.wr_data,    32'h0);
        rst = 1'b0;
        step();
        check("idle_byte_ready", bus.byte_ready, 0);

        // Clean two-word image, back-to-back bytes
        base = n_wr;
        pulse_start();
        check("t2_byte_ready", bus.byte_ready, 1);
        check("t2_cpu_hold",   bus.cpu_hold,   1);
        send(8'h13, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        check("t2_no_wr_partial", bus.wr_en, 0);
        send(8'h00, 1'b0);
        check("t2_wr0_en",   bus.wr_en,   1);
        check("t2_wr0_addr", bus.wr_addr, 32'h0);
        check("t2_wr0_data", bus.wr_data, 32'h0000_0013);
        check("t2_wr0_count", bus.word_count, 1);
        send(8'h93, 1'b0);
        check("t2_wr_pulse_one_cycle", bus.wr_en, 0);
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h00, 1'b1);
        check("t2_wr1_en",   bus.wr_en,   1);
        check("t2_wr1_addr", bus.wr_addr, 32'h4);
        check("t2_wr1_data", bus.wr_data, 32'h0010_0093);
        check("t2_done_not_with_wr", bus.done, 0);
        check("t2_hold_with_wr",     bus.cpu_hold, 1);
        check("t2_flush_not_ready",  bus.byte_ready, 0);
        step();
        check("t2_done",       bus.done,       1);
        check("t2_cpu_hold",   bus.cpu_hold,   0);
        check("t2_error",      bus.error,      0);
        check("t2_wr_en_low",  bus.wr_en,      0);
        check("t2_word_count", bus.word_count, 2);
        check("t2_done_not_ready", bus.byte_ready, 0);
        check("t2_num_writes", n_wr - base, 2);

        // Same image with idle cycles between bytes
        base = n_wr;
        pulse_start();
        check("t3_count_cleared", bus.word_count, 0);
        check("t3_done_cleared",  bus.done,       0);
        check("t3_hold_again",    bus.cpu_hold,   1);
        for (int i = 0; i < 8; i++) begin
            send(img[i], i == 7);
            if (i == 3) begin
                check("t3_wr0_en",   bus.wr_en,   1);
                check("t3_wr0_addr", bus.wr_addr, 32'h0);
                check("t3_wr0_data", bus.wr_data, 32'h0000_0013);
            end else if (i == 7) begin
                check("t3_wr1_en",   bus.wr_en,   1);
                check("t3_wr1_addr", bus.wr_addr, 32'h4);
                check("t3_wr1_data", bus.wr_data, 32'h0010_0093);
            end else begin
                check("t3_no_wr_partial", bus.wr_en, 0);
                step();
                check("t3_no_wr_gap", bus.wr_en, 0);
            end
            if (i == 3) step();
        end
        step();
        check("t3_done",       bus.done,       1);
        check("t3_word_count", bus.word_count, 2);
        check("t3_num_writes", n_wr - base, 2);

        // Partial final word: zero-padded write, then error
        base = n_wr;
        pulse_start();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        check("t4_wr_en",   bus.wr_en,   1);
        check("t4_wr_addr", bus.wr_addr, 32'h0);
        check("t4_wr_data", bus.wr_data, 32'h0000_BBAA);
        step();
        check("t4_error",      bus.error,      1);
        check("t4_cpu_hold",   bus.cpu_hold,   1);
        check("t4_done",       bus.done,       0);
        check("t4_word_count", bus.word_count, 1);
        check("t4_not_ready",  bus.byte_ready, 0);
        check("t4_num_writes", n_wr - base, 1);
        send(8'h55, 1'b1);
        check("t4_ignored_in_error", bus.wr_en, 0);

        // Overflow on the 4-word instance
        base = n_wr_s;
        bus_s.start = 1'b1;
        step();
        bus_s.start = 1'b0;
        check("t5_ready", bus_s.byte_ready, 1);
        for (int i = 0; i < 20; i++) begin
            bus_s.byte_valid = 1'b1;
            bus_s.byte_data  = 8'(i + 1);
            bus_s.byte_last  = 1'b0;
            step();
            if ((i % 4 == 3) && (i < 16)) begin
                check("t5_wr_en",   bus_s.wr_en,   1);
                check("t5_wr_addr", bus_s.wr_addr, 32'(i - 3));
                check("t5_wr_data", bus_s.wr_data, {8'(i + 1), 8'(i), 8'(i - 1), 8'(i - 2)});
            end else if (i == 19) begin
                check("t5_ovf_no_wr", bus_s.wr_en,      0);
                check("t5_ovf_error", bus_s.error,      1);
                check("t5_ovf_ready", bus_s.byte_ready, 0);
            end else begin
                check("t5_no_wr_partial", bus_s.wr_en, 0);
            end
        end
        bus_s.byte_valid = 1'b0;
        step();
        check("t5_still_no_wr", bus_s.wr_en,      0);
        check("t5_word_count",  bus_s.word_count, 4);
        check("t5_hold",        bus_s.cpu_hold,   1);
        check("t5_done",        bus_s.done,       0);
        check("t5_num_writes",  n_wr_s - base,    4);

        // Reset in the middle of a word, then restart
        base = n_wr;
        pulse_start();
        send(8'h77, 1'b0);
        send(8'h66, 1'b0);
        rst = 1'b1;
        step();
        check("t6_rst_wr_en",   bus.wr_en,      0);
        check("t6_rst_count",   bus.word_count, 0);
        check("t6_rst_error",   bus.error,      0);
        check("t6_rst_ready",   bus.byte_ready, 0);
        check("t6_rst_hold",    bus.cpu_hold,   1);
        check("t6_rst_wr_addr", bus.wr_addr,    32'h0);
        rst = 1'b0;
        pulse_start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check("t6_no_early_wr", bus.wr_en, 0);
        send(8'h44, 1'b0);
        check("t6_wr_en",   bus.wr_en,   1);
        check("t6_wr_addr", bus.wr_addr, 32'h0);
        check("t6_wr_data", bus.wr_data, 32'h4433_2211);
        step();
        check("t6_word_count", bus.word_count, 1);
        check("t6_num_writes", n_wr - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
